// File: rtl/ring_pkg.sv
// ring_pkg: shared constants and FSM state type for the ring-counter decoder.
package ring_pkg;
    localparam int RING_W = 8;
    localparam int IDX_W  = 3;
    localparam int CNT_W  = 4;
    typedef enum logic [1:0] {UNLOCK, TRACK, LOCKED} state_t;
endpackage

// File: rtl/ring_onehot_enc.sv
// ring_onehot_enc: one-hot word to bit index, with an exactly-one-bit-set flag.
module ring_onehot_enc
    import ring_pkg::*;
(
    input  logic [RING_W-1:0] q,
    output logic [IDX_W-1:0]  idx,
    output logic              onehot
);
    always_comb begin
        idx = '0;
        for (int i = 0; i < RING_W; i++)
            if (q[i]) idx = IDX_W'(i);
    end
    assign onehot = (q != '0) && ((q & (q - 1'b1)) == '0);
endmodule

// File: rtl/ring_decoder.sv
// ring_decoder: ring-counter decoder with lock tracking, lap and error counting.
// Define RING_ERRCNT_EN to build the saturating err_cnt counter; otherwise err_cnt is tied to 0.
module ring_decoder
    import ring_pkg::*;
#(
    parameter int LOCK_N = 4,
    parameter int LOSS_N = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sample_en,
    input  logic [RING_W-1:0] q_in,
    output logic [IDX_W-1:0]  idx,
    output logic              valid,
    output logic              locked,
    output logic              err,
    output logic [7:0]        lap_cnt,
    output logic [7:0]        err_cnt
);
    state_t            state, state_nx;
    logic [CNT_W-1:0]  run, run_nx, miss, miss_nx;
    logic [RING_W-1:0] prev;
    logic [IDX_W-1:0]  enc_idx;
    logic              oh, good, bad_lk, lap_hit;

    ring_onehot_enc u_enc (.q(q_in), .idx(enc_idx), .onehot(oh));

    // prev resets to 0, so the first sample after reset can never be good
    assign good    = oh && (q_in == {prev[RING_W-2:0], prev[RING_W-1]});
    assign bad_lk  = sample_en && (state == LOCKED) && !good;
    assign lap_hit = sample_en && (state == LOCKED) && good && (prev == 8'h80);

    always_comb begin
        state_nx = state;
        run_nx   = run;
        miss_nx  = miss;
        if (sample_en) begin
            case (state)
                UNLOCK: if (oh) begin
                    state_nx = TRACK;
                    run_nx   = '0;
                end
                TRACK: if (good) begin
                    run_nx = run + 1'b1;
                    if (run_nx == CNT_W'(LOCK_N)) begin
                        state_nx = LOCKED;
                        miss_nx  = '0;
                    end
                end else if (oh) begin
                    run_nx = '0;
                end else begin
                    state_nx = UNLOCK;
                end
                LOCKED: if (good) begin
                    miss_nx = '0;
                end else begin
                    miss_nx = miss + 1'b1;
                    if (miss_nx == CNT_W'(LOSS_N)) begin
                        state_nx = UNLOCK;
                        miss_nx  = '0;
                    end
                end
                default: state_nx = UNLOCK;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= UNLOCK;
            run     <= '0;
            miss    <= '0;
            prev    <= '0;
            idx     <= '0;
            valid   <= 1'b0;
            locked  <= 1'b0;
            err     <= 1'b0;
            lap_cnt <= '0;
        end else begin
            state  <= state_nx;
            run    <= run_nx;
            miss   <= miss_nx;
            locked <= (state_nx == LOCKED);
            err    <= bad_lk;
            if (sample_en) begin
                prev  <= q_in;
                valid <= oh;
                if (oh) idx <= enc_idx;
            end
            if (lap_hit) lap_cnt <= lap_cnt + 1'b1;
        end
    end

`ifdef RING_ERRCNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) err_cnt <= '0;
        else if (bad_lk && err_cnt != 8'hff) err_cnt <= err_cnt + 1'b1;
    end
`else
    assign err_cnt = '0;
`endif
endmodule

// File: tb/tb_ring_decoder.sv
// tb_ring_decoder: directed and random stimulus against an arithmetic reference model.
// Expects err_cnt counting only when RING_ERRCNT_EN is defined.
module tb_ring_decoder;
    localparam int LOCK_N = 4;
    localparam int LOSS_N = 2;

    logic       clk = 0, rst = 0, sample_en = 0;
    logic [7:0] q_in = 0;
    logic [2:0] idx;
    logic       valid, locked, err;
    logic [7:0] lap_cnt, err_cnt;

    int n_chk = 0, n_fail = 0;
    int m_state, m_run, m_miss, m_idx, m_lap, m_errc;
    logic [7:0] m_prev;
    logic m_valid, m_err;

    ring_decoder #(.LOCK_N(LOCK_N), .LOSS_N(LOSS_N)) dut (
        .clk(clk), .rst(rst), .sample_en(sample_en), .q_in(q_in),
        .idx(idx), .valid(valid), .locked(locked), .err(err),
        .lap_cnt(lap_cnt), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    // rotate-left by one as doubling modulo 255 (exact for every one-hot word)
    function automatic logic [7:0] rotl(input logic [7:0] v);
        return 8'((int'(v) * 2) % 255);
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".idx"}, int'(idx), m_idx);
        chk({tag, ".valid"}, int'(valid), int'(m_valid));
        chk({tag, ".locked"}, int'(locked), int'(m_state == 2));
        chk({tag, ".err"}, int'(err), int'(m_err));
        chk({tag, ".lap_cnt"}, int'(lap_cnt), m_lap);
        chk({tag, ".err_cnt"}, int'(err_cnt), m_errc);
    endtask

    task automatic model_reset();
        m_state = 0; m_run = 0; m_miss = 0; m_idx = 0; m_lap = 0; m_errc = 0;
        m_prev = 0; m_valid = 0; m_err = 0;
    endtask

    task automatic model(input logic en, input logic [7:0] q);
        bit oh, good;
        m_err = 0;
        if (!en) return;
        oh   = $countones(q) == 1;
        good = oh && $countones(m_prev) == 1 && q == rotl(m_prev);
        if (m_state == 0) begin
            if (oh) begin m_state = 1; m_run = 0; end
        end else if (m_state == 1) begin
            if (good) begin
                m_run++;
                if (m_run >= LOCK_N) begin m_state = 2; m_miss = 0; end
            end else if (oh) m_run = 0;
            else m_state = 0;
        end else begin
            if (good) begin
                m_miss = 0;
                if (m_prev == 8'h80) m_lap = (m_lap + 1) % 256;
            end else begin
                m_err = 1;
`ifdef RING_ERRCNT_EN
                if (m_errc < 255) m_errc++;
`endif
                m_miss++;
                if (m_miss >= LOSS_N) begin m_state = 0; m_miss = 0; end
            end
        end
        m_valid = oh;
        if (oh) for (int i = 0; i < 8; i++) if (q[i]) m_idx = i;
        m_prev = q;
    endtask

    task automatic step(input logic en, input logic [7:0] q, input string tag);
        sample_en = en;
        q_in = q;
        @(posedge clk);
        model(en, q);
        #1;
        check_all(tag);
    endtask

    task automatic do_reset(input string tag);
        rst = 0;
        #2;
        model_reset();
        check_all(tag);
        @(posedge clk);
        #1;
        rst = 1;
    endtask

    initial begin
        logic [7:0] cur, snap_q;
        int lap0;
        model_reset();
        #3;
        check_all("por");
        @(posedge clk);
        #1;
        rst = 1;

        // acquisition: lock after the 5th rotating sample
        cur = 8'h01;
        for (int i = 0; i < 5; i++) begin
            step(1, cur, "acq");
            chk("acq.idxlag", int'(idx), i);
            chk("acq.lockedat", int'(locked), int'(i == 4));
            cur = rotl(cur);
        end

        // three laps, then 256 more laps plus a remainder
        lap0 = int'(lap_cnt);
        for (int i = 0; i < 24; i++) begin step(1, cur, "lap3"); cur = rotl(cur); end
        chk("lap3.cnt", int'(lap_cnt), (lap0 + 3) % 256);
        for (int i = 0; i < 256 * 8 + 16; i++) begin step(1, cur, "lap256"); cur = rotl(cur); end
        chk("lap256.wrap", int'(lap_cnt), (lap0 + 5) % 256);

        // single bad word keeps lock, second consecutive bad word drops it
        step(1, 8'h11, "bad1");
        chk("bad1.err", int'(err), 1);
        chk("bad1.locked", int'(locked), 1);
        chk("bad1.valid", int'(valid), 0);
        step(1, cur, "bad2");
        chk("bad2.locked", int'(locked), 0);
        step(0, 8'h00, "idle");
        chk("idle.err", int'(err), 0);

        // skip a step while tracking, then while locked, then inject zero
        step(1, 8'h01, "skip"); step(1, 8'h02, "skip"); step(1, 8'h08, "skip");
        cur = 8'h10;
        for (int i = 0; i < LOCK_N; i++) begin step(1, cur, "relock"); cur = rotl(cur); end
        chk("relock.locked", int'(locked), 1);
        step(1, rotl(cur), "skiplk");
        chk("skiplk.err", int'(err), 1);
        step(1, 8'h00, "zero");
        chk("zero.locked", int'(locked), 0);

        // sample_en low with a toggling bus: nothing changes, then resume cleanly
        cur = 8'h01;
        for (int i = 0; i < 5; i++) begin step(1, cur, "lock3"); cur = rotl(cur); end
        snap_q = {5'b0, idx};
        for (int i = 0; i < 10; i++) step(0, 8'($urandom), "hold");
        chk("hold.idx", int'(idx), int'(snap_q));
        step(1, cur, "resume");
        chk("resume.err", int'(err), 0);
        cur = rotl(cur);

        // reset in the middle of a lap
        for (int i = 0; i < 8 * 5; i++) begin step(1, cur, "pre_rst"); cur = rotl(cur); end
        do_reset("midrst");
        chk("midrst.lap", int'(lap_cnt), 0);
        step(1, cur, "post_rst");
        step(1, rotl(cur), "post_rst");
        chk("post_rst.locked", int'(locked), 0);

        // random mix of correct rotations, skips, zeros and garbage
        cur = 8'h01;
        for (int i = 0; i < 600; i++) begin
            int r;
            logic en;
            logic [7:0] q;
            r  = $urandom_range(99);
            en = $urandom_range(99) < 85;
            q  = (r < 70) ? rotl(cur) :
                 (r < 80) ? 8'(1 << $urandom_range(7)) :
                 (r < 85) ? 8'h00 : 8'($urandom);
            if ($countones(q) != 1 && r < 70) q = 8'h01;
            step(en, q, "rand");
            if (en && $countones(q) == 1) cur = q;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
